// File: rtl/phys_reg_freelist_if.sv
// ============================================================================
// Module      : phys_reg_freelist_if
// Description : Rename/retire/flush handshake bundle for the physical register
//               free list. The master side is the pipeline (Rename, Retire,
//               flush control); the slave side is the free-list controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface phys_reg_freelist_if #(
    parameter int NUM_ARCH = 32,
    parameter int TAG_W    = 6
);
    logic                      alloc_req;
    logic                      alloc_grant;
    logic [TAG_W-1:0]          alloc_reg;
    logic                      free_valid;
    logic [TAG_W-1:0]          free_reg;
    logic                      flush;
    logic [NUM_ARCH*TAG_W-1:0] rrat_map;
    logic [TAG_W:0]            free_count;
    logic                      halt;
    logic                      overflow_err;

    modport master (
        output alloc_req, free_valid, free_reg, flush, rrat_map,
        input  alloc_grant, alloc_reg, free_count, halt, overflow_err
    );

    modport slave (
        input  alloc_req, free_valid, free_reg, flush, rrat_map,
        output alloc_grant, alloc_reg, free_count, halt, overflow_err
    );
endinterface

`default_nettype wire

// File: rtl/phys_reg_freelist.sv
// ============================================================================
// Module      : phys_reg_freelist
// Description : Free-list controller for the physical register file. Hands
//               out one free tag per cycle, reclaims tags at retirement and
//               rebuilds the list from the RRAT after a flush by scanning
//               every physical index once.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phys_reg_freelist #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int TAG_W    = 6
) (
    input  wire logic            CLK,
    input  wire logic            RESET,
    phys_reg_freelist_if.slave   bus
);

    localparam int DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [TAG_W-1:0] LAST_IDX   = TAG_W'(NUM_PHYS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [TAG_W-1:0]    fifo [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [TAG_W-1:0]    scan_idx;
    logic [NUM_PHYS-1:0] used;
    logic [NUM_PHYS-1:0] snap_used;
    logic                overflow;

    logic                in_idle;
    logic                grant;
    logic                free_ok;
    logic                scan_hit;
    logic                push_req;
    logic                push;
    logic                push_drop;
    logic [TAG_W-1:0]    push_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Grant/push qualification; a flush suppresses all same-cycle list updates
    always_comb begin
        in_idle   = (state == IDLE);
        grant     = in_idle && !bus.flush && bus.alloc_req && (count != '0);
        free_ok   = in_idle && !bus.flush && bus.free_valid && (bus.free_reg != '0);
        scan_hit  = (state == SCAN) && !bus.flush && !used[scan_idx];
        push_req  = free_ok || scan_hit;
        push      = push_req && (count != FULL_COUNT);
        push_drop = push_req && (count == FULL_COUNT);
        push_tag  = (state == SCAN) ? scan_idx : bus.free_reg;
    end

    // Bitmap of tags the RRAT still holds; phys 0 is permanently arch r0
    always_comb begin
        snap_used    = '0;
        snap_used[0] = 1'b1;
        for (int r = 0; r < NUM_ARCH; r++) begin
            snap_used[bus.rrat_map[r*TAG_W +: TAG_W]] = 1'b1;
        end
    end

    // Recovery sequencer state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: any flush restarts at SNAP, SCAN ends after the last index
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = SNAP;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                SNAP:    state_nxt = SCAN;
                SCAN:    state_nxt = (scan_idx == LAST_IDX) ? IDLE : SCAN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // List storage: preloaded with the tags not owned by any arch reg at reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= TAG_W'(NUM_ARCH + i);
            end
        end else if (push && !(state == SNAP)) begin
            fifo[tail] <= push_tag;
        end
    end

    // Pointers, occupancy, scan index, snapshot and sticky overflow flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head     <= '0;
            tail     <= '0;
            count    <= FULL_COUNT;
            scan_idx <= '0;
            used     <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (state == SNAP) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                scan_idx <= '0;
                used     <= snap_used;
            end else begin
                if (push) begin
                    tail <= ptr_inc(tail);
                end
                if (grant) begin
                    head <= ptr_inc(head);
                end
                if (push && !grant) begin
                    count <= count + 1'b1;
                end else if (grant && !push) begin
                    count <= count - 1'b1;
                end
                if (state == SCAN) begin
                    scan_idx <= scan_idx + 1'b1;
                end
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.alloc_grant  = grant;
    assign bus.alloc_reg    = fifo[head];
    assign bus.free_count   = count;
    assign bus.halt         = !in_idle || (count == '0);
    assign bus.overflow_err = overflow;

endmodule

`default_nettype wire

// File: tb/tb_phys_reg_freelist.sv
// ============================================================================
// Module      : tb_phys_reg_freelist
// Description : Scoreboard bench for phys_reg_freelist. Stimulus pushes the
//               expected per-cycle status and the expected granted tags into
//               queues; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phys_reg_freelist;

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int TAG_W    = 6;

    typedef struct {
        string name;
        int    cnt;     // -1 = don't care
        int    halt;
        int    ovf;
        int    grant;
        int    areg;
        bit    empty;   // check that every expected grant was seen
    } stat_t;

    logic clk;
    logic rst;

    phys_reg_freelist_if #(.NUM_ARCH(NUM_ARCH), .TAG_W(TAG_W)) bus ();

    phys_reg_freelist #(
        .NUM_PHYS (NUM_PHYS),
        .NUM_ARCH (NUM_ARCH),
        .TAG_W    (TAG_W)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    stat_t stat_q [$];
    int    tag_q  [$];
    int    tests;
    int    fails;
    bit    done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares one status record per cycle and every observed grant
    task automatic cmp(input string n, input int act, input int exp);
        if (exp >= 0) begin
            tests++;
            if (act != exp) begin
                fails++;
                $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        stat_t s;
        int    t;
        if (bus.alloc_grant) begin
            if (tag_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_grant: got tag %0d expected no grant (t=%0t)",
                         bus.alloc_reg, $time);
            end else begin
                t = tag_q.pop_front();
                cmp("granted_tag", int'(bus.alloc_reg), t);
            end
        end
        if (stat_q.size() != 0) begin
            s = stat_q.pop_front();
            cmp({s.name, ".free_count"}, int'(bus.free_count), s.cnt);
            cmp({s.name, ".halt"}, int'(bus.halt), s.halt);
            cmp({s.name, ".overflow_err"}, int'(bus.overflow_err), s.ovf);
            cmp({s.name, ".alloc_grant"}, int'(bus.alloc_grant), s.grant);
            cmp({s.name, ".alloc_reg"}, int'(bus.alloc_reg), s.areg);
            if (s.empty) begin
                cmp({s.name, ".pending_grants"}, tag_q.size(), 0);
                done = 1'b1;
            end
        end
    end

    // Stimulus helpers
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit req, input bit fv, input int fr, input bit fl);
        bus.alloc_req  = req;
        bus.free_valid = fv;
        bus.free_reg   = TAG_W'(fr);
        bus.flush      = fl;
    endtask

    task automatic expect_st(input string n, input int c, input int h, input int o,
                             input int g, input int r);
        stat_t s;
        s = '{name: n, cnt: c, halt: h, ovf: o, grant: g, areg: r, empty: 1'b0};
        stat_q.push_back(s);
        if (g == 1 && r >= 0) tag_q.push_back(r);
    endtask

    initial begin
        logic [NUM_ARCH*TAG_W-1:0] map;
        tests = 0;
        fails = 0;
        done  = 1'b0;
        rst   = 1'b1;
        drive(0, 0, 0, 0);
        bus.rrat_map = '0;
        repeat (2) cyc();
        rst = 1'b0;

        // Reset state
        cyc();
        expect_st("reset", 32, 0, 0, 0, 32);

        // Drain: 32 grants in order, 33rd denied
        for (int i = 0; i < 33; i++) begin
            cyc();
            drive(1, 0, 0, 0);
            if (i < 32) expect_st("drain", 32 - i, 0, 0, 1, 32 + i);
            else        expect_st("drain_empty", 0, 1, 0, 0, -1);
        end

        // Empty list: same-cycle free is not bypassed
        cyc();
        drive(1, 1, 50, 0);
        expect_st("nobypass", 0, 1, 0, 0, -1);
        cyc();
        drive(1, 0, 0, 0);
        expect_st("nobypass_next", 1, 0, 0, 1, 50);

        // Fill to 5, then simultaneous grant + free of 40
        for (int j = 0; j < 5; j++) begin
            cyc();
            drive(0, 1, 10 + j, 0);
            expect_st("fill5", j, (j == 0) ? 1 : 0, 0, 0, -1);
        end
        cyc();
        drive(1, 1, 40, 0);
        expect_st("simul", 5, 0, 0, 1, 10);
        cyc();
        drive(1, 0, 0, 0);
        expect_st("simul_after", 5, 0, 0, 1, 11);
        cyc(); expect_st("pop12", 4, 0, 0, 1, 12);
        cyc(); expect_st("pop13", 3, 0, 0, 1, 13);
        cyc(); expect_st("pop14", 2, 0, 0, 1, 14);
        cyc(); expect_st("pop40", 1, 0, 0, 1, 40);
        cyc();
        drive(0, 0, 0, 0);
        expect_st("empty_again", 0, 1, 0, 0, -1);

        // Free of tag 0 is ignored
        cyc();
        drive(0, 1, 0, 0);
        expect_st("free0", 0, 1, 0, 0, -1);
        cyc();
        drive(0, 0, 0, 0);
        expect_st("free0_after", 0, 1, 0, 0, -1);

        // Refill to full, then one extra free overflows
        for (int k = 0; k < 32; k++) begin
            cyc();
            drive(0, 1, 32 + k, 0);
            expect_st("refill", k, (k == 0) ? 1 : 0, 0, 0, -1);
        end
        cyc();
        drive(0, 1, 1, 0);
        expect_st("full_free", 32, 0, 0, 0, -1);
        cyc();
        drive(0, 0, 0, 0);
        expect_st("overflow", 32, 0, 1, 0, -1);
        cyc();
        expect_st("overflow_sticky", 32, 0, 1, 0, -1);

        // Flush with identity RRAT except arch5 -> 40
        for (int r = 0; r < NUM_ARCH; r++) map[r*TAG_W +: TAG_W] = TAG_W'(r);
        map[5*TAG_W +: TAG_W] = TAG_W'(40);
        bus.rrat_map = map;
        cyc();
        drive(0, 0, 0, 1);
        expect_st("flush_cycle", -1, -1, 1, 0, -1);
        for (int c = 0; c < 65; c++) begin
            cyc();
            drive(1, 1, 7, 0);
            expect_st("recover", -1, 1, 1, 0, -1);
        end
        cyc();
        drive(1, 0, 0, 0);
        expect_st("rebuilt", 32, 0, 1, 1, 5);
        for (int t = 32; t < 64; t++) begin
            if (t == 40) continue;
            cyc();
            expect_st("rebuilt_order", -1, 0, 1, 1, t);
        end
        cyc();
        drive(0, 0, 0, 0);
        expect_st("rebuilt_empty", 0, 1, 1, 0, -1);

        // Async reset in the middle of a recovery
        cyc();
        drive(0, 0, 0, 1);
        expect_st("flush2", -1, -1, 1, 0, -1);
        for (int c = 0; c < 10; c++) begin
            cyc();
            drive(1, 0, 0, 0);
            expect_st("recover2", -1, 1, 1, 0, -1);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        drive(0, 0, 0, 0);
        expect_st("reset_mid_scan", 32, 0, 0, 0, 32);
        cyc();
        rst = 1'b0;
        cyc();
        drive(1, 0, 0, 0);
        expect_st("post_reset_grant", 32, 0, 0, 1, 32);
        cyc();
        drive(0, 0, 0, 0);
        stat_q.push_back('{name: "final", cnt: 31, halt: 0, ovf: 0, grant: 0,
                           areg: 33, empty: 1'b1});

        for (int w = 0; w < 20 && !done; w++) cyc();
        if (!done) begin
            $display("FAIL monitor_timeout: got no final check expected one within 20 cycles");
            $fatal(1, "monitor timeout");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
